// File: rtl/vga_timing_pipe.sv
// rtl/vga_timing_pipe.sv - parametrised VGA timing with scaled frame-buffer fetch and latency-matched outputs
module vga_timing_pipe #(
   parameter int   HD          = 640,
   parameter int   HF          = 16,
   parameter int   HS          = 96,
   parameter int   HB          = 48,
   parameter int   VD          = 480,
   parameter int   VF          = 10,
   parameter int   VS          = 2,
   parameter int   VB          = 33,
   parameter logic HS_ACT      = 1'b0,
   parameter logic VS_ACT      = 1'b0,
   parameter int   SCALE_SHIFT = 2,
   parameter int   IMG_W       = 160,
   parameter int   ADDR_W      = 15,
   parameter int   PIXEL_W     = 12,
   parameter int   MEM_LAT     = 1
) (
   input  logic               pclk,
   input  logic               reset,
   output logic [ADDR_W-1:0]  fetch_addr,
   input  logic [PIXEL_W-1:0] pix_data,
   output logic [PIXEL_W-1:0] pixel_out,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic               frame_start,
   output logic               line_start
);
   localparam int HT = HD + HF + HS + HB;
   localparam int VT = VD + VF + VS + VB;
   localparam int HW = $clog2(HT);
   localparam int VW = $clog2(VT);

   localparam logic [HW-1:0] H_LAST     = HW'(HT - 1);
   localparam logic [HW-1:0] H_ACT      = HW'(HD);
   localparam logic [HW-1:0] H_SYNC_ON  = HW'(HD + HF);
   localparam logic [HW-1:0] H_SYNC_OFF = HW'(HD + HF + HS);
   localparam logic [VW-1:0] V_LAST     = VW'(VT - 1);
   localparam logic [VW-1:0] V_ACT      = VW'(VD);
   localparam logic [VW-1:0] V_SYNC_ON  = VW'(VD + VF);
   localparam logic [VW-1:0] V_SYNC_OFF = VW'(VD + VF + VS);

   // Bit positions of the stage-0 flags carried through the delay line
   localparam int F_LS  = 0;
   localparam int F_FS  = 1;
   localparam int F_VS  = 2;
   localparam int F_HS  = 3;
   localparam int F_ACT = 4;

   logic [HW-1:0]            h_q, h_d;
   logic [VW-1:0]            v_q, v_d;
   logic [4:0]               st0;
   logic [ADDR_W-1:0]        addr_full;
   logic [MEM_LAT-1:0][4:0]  dly_q, dly_d;
   logic [4:0]               nxt;
   logic                     hsync_q, hsync_d;
   logic                     vsync_q, vsync_d;
   logic                     de_q, de_d;
   logic                     fs_q, fs_d;
   logic                     ls_q, ls_d;
   logic [PIXEL_W-1:0]       pix_q, pix_d;

   always_comb begin
      h_d = h_q + 1'b1;
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end
   end

   always_comb begin
      st0        = '0;
      st0[F_ACT] = (h_q < H_ACT) && (v_q < V_ACT);
      st0[F_HS]  = (h_q >= H_SYNC_ON) && (h_q < H_SYNC_OFF);
      st0[F_VS]  = (v_q >= V_SYNC_ON) && (v_q < V_SYNC_OFF);
      st0[F_FS]  = (h_q == '0) && (v_q == '0);
      st0[F_LS]  = (h_q == '0) && (v_q < V_ACT);
      // Truncating each term to ADDR_W first gives the same low bits as truncating the full sum
      addr_full  = ADDR_W'(v_q >> SCALE_SHIFT) * ADDR_W'(IMG_W) + ADDR_W'(h_q >> SCALE_SHIFT);
      fetch_addr = st0[F_ACT] ? addr_full : '0;
   end

   always_comb begin
      dly_d    = dly_q;
      dly_d[0] = st0;
      for (int i = 1; i < MEM_LAT; i++) begin
         dly_d[i] = dly_q[i-1];
      end
   end

   always_comb begin
      nxt     = dly_q[MEM_LAT-1];
      hsync_d = nxt[F_HS] ? HS_ACT : ~HS_ACT;
      vsync_d = nxt[F_VS] ? VS_ACT : ~VS_ACT;
      de_d    = nxt[F_ACT];
      fs_d    = nxt[F_FS];
      ls_d    = nxt[F_LS];
      pix_d   = nxt[F_ACT] ? pix_data : '0;
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         h_q     <= '0;
         v_q     <= '0;
         dly_q   <= '0;
         hsync_q <= ~HS_ACT;
         vsync_q <= ~VS_ACT;
         de_q    <= 1'b0;
         fs_q    <= 1'b0;
         ls_q    <= 1'b0;
         pix_q   <= '0;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         dly_q   <= dly_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         de_q    <= de_d;
         fs_q    <= fs_d;
         ls_q    <= ls_d;
         pix_q   <= pix_d;
      end
   end

   assign pixel_out   = pix_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign frame_start = fs_q;
   assign line_start  = ls_q;
endmodule

// File: tb/tb_vga_timing_pipe.sv
// tb/tb_vga_timing_pipe.sv - directed bench: default-size instance plus a small MEM_LAT=3 instance
module tb_vga_timing_pipe;
   logic        pclk = 1'b0;
   always #20 pclk = ~pclk;

   logic        reset_def, hsync_def, vsync_def, de_def, fs_def, ls_def;
   logic [14:0] fetch_def;
   logic [11:0] pix_def, pixel_def;

   logic        reset_sm, hsync_sm, vsync_sm, de_sm, fs_sm, ls_sm;
   logic [7:0]  fetch_sm;
   logic [11:0] pix_sm, pixel_sm;
   logic [7:0]  m0 = 8'h00, m1 = 8'h00, m2 = 8'h00;

   int checks = 0;
   int errors = 0;
   int t_def  = 0;
   int t_sm   = 0;

   vga_timing_pipe u_def (
      .pclk(pclk), .reset(reset_def), .fetch_addr(fetch_def), .pix_data(pix_def),
      .pixel_out(pixel_def), .hsync(hsync_def), .vsync(vsync_def), .de(de_def),
      .frame_start(fs_def), .line_start(ls_def)
   );

   // HT=48, VT=24, hsync active-high, vsync active-low, 3-cycle memory
   vga_timing_pipe #(
      .HD(32), .HF(4), .HS(8), .HB(4), .VD(16), .VF(2), .VS(2), .VB(4),
      .HS_ACT(1'b1), .VS_ACT(1'b0), .SCALE_SHIFT(2), .IMG_W(8), .ADDR_W(8),
      .PIXEL_W(12), .MEM_LAT(3)
   ) u_sm (
      .pclk(pclk), .reset(reset_sm), .fetch_addr(fetch_sm), .pix_data(pix_sm),
      .pixel_out(pixel_sm), .hsync(hsync_sm), .vsync(vsync_sm), .de(de_sm),
      .frame_start(fs_sm), .line_start(ls_sm)
   );

   always @(posedge pclk) begin
      m0 <= fetch_sm;
      m1 <= m0;
      m2 <= m1;
   end
   assign pix_sm = {4'h5, m2};

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step_def();
      @(negedge pclk);
      t_def++;
   endtask

   task automatic step_sm();
      @(negedge pclk);
      t_sm++;
   endtask

   task automatic test_reset();
      reset_def = 1'b1;
      reset_sm  = 1'b1;
      pix_def   = 12'hFFF;
      for (int i = 0; i < 5; i++) begin
         @(negedge pclk);
         checks++;
         if ({hsync_def, vsync_def, de_def, fs_def, ls_def, pixel_def} !== {5'b11000, 12'h000}) begin
            errors++;
            $display("FAIL reset_def cycle %0d: got hs/vs/de/fs/ls=%b%b%b%b%b pix=%h, expected 11000 pix=000",
                     i, hsync_def, vsync_def, de_def, fs_def, ls_def, pixel_def);
         end
      end
      checks++;
      if ({hsync_sm, vsync_sm, de_sm, fs_sm, ls_sm, pixel_sm} !== {5'b01000, 12'h000}) begin
         errors++;
         $display("FAIL reset_sm: got hs/vs/de/fs/ls=%b%b%b%b%b pix=%h, expected 01000 pix=000",
                  hsync_sm, vsync_sm, de_sm, fs_sm, ls_sm, pixel_sm);
      end
   endtask

   task automatic test_start_def();
      reset_def = 1'b0;
      t_def     = 0;
      checks++;
      if (fetch_def !== 15'd0) begin
         errors++;
         $display("FAIL start_addr00: got %0d expected 0", fetch_def);
      end
      for (int i = 0; i < 10 && fs_def !== 1'b1; i++) step_def();
      checks++;
      if (fs_def !== 1'b1 || t_def != 2) begin
         errors++;
         $display("FAIL first_frame_start_def: got fs=%b at cycle %0d, expected fs=1 at cycle 2", fs_def, t_def);
      end
      checks++;
      if ({de_def, ls_def, pixel_def} !== {2'b11, 12'hFFF}) begin
         errors++;
         $display("FAIL origin_pixel_def: got de=%b ls=%b pix=%h, expected de=1 ls=1 pix=fff",
                  de_def, ls_def, pixel_def);
      end
      step_def();
      checks++;
      if (fs_def !== 1'b0) begin
         errors++;
         $display("FAIL frame_start_pulse_width: got fs=%b expected 0", fs_def);
      end
   endtask

   task automatic test_addr_def();
      int kv[11] = '{3, 4, 7, 8, 639, 640, 799, 800, 3200, 4005, 6239};
      int av[11] = '{0, 1, 1, 2, 159, 0,   0,   0,   160,  161,  319};
      for (int i = 0; i < 11; i++) begin
         while (t_def < kv[i]) step_def();
         checks++;
         if (fetch_def !== 15'(av[i])) begin
            errors++;
            $display("FAIL fetch_addr at (%0d,%0d): got %0d expected %0d",
                     kv[i] % 800, kv[i] / 800, fetch_def, av[i]);
         end
      end
   endtask

   task automatic test_line_def();
      for (int i = 0; i < 1000 && ls_def !== 1'b1; i++) step_def();
      checks++;
      if (ls_def !== 1'b1) begin
         errors++;
         $display("FAIL line_start_wait: got ls=%b expected 1 within 1000 cycles", ls_def);
      end
      for (int line = 0; line < 3; line++) begin
         int de_cnt = 0, de_first = -1, de_last = -1, hs_cnt = 0, hs_first = -1;
         int pix_bad = 0, ls_early = 0;
         for (int off = 0; off < 800; off++) begin
            if (de_def === 1'b1) begin
               de_cnt++;
               if (de_first < 0) de_first = off;
               de_last = off;
               if (pixel_def !== 12'hFFF) pix_bad++;
            end else if (pixel_def !== 12'h000) begin
               pix_bad++;
            end
            if (hsync_def === 1'b0) begin
               hs_cnt++;
               if (hs_first < 0) hs_first = off;
            end
            if (off > 0 && ls_def !== 1'b0) ls_early++;
            step_def();
         end
         checks++;
         if (de_cnt != 640 || de_first != 0 || de_last != 639) begin
            errors++;
            $display("FAIL line%0d_de: got count=%0d span %0d..%0d, expected count=640 span 0..639",
                     line, de_cnt, de_first, de_last);
         end
         checks++;
         if (hs_first != 656 || hs_cnt != 96) begin
            errors++;
            $display("FAIL line%0d_hsync: got start=%0d width=%0d, expected start=656 width=96",
                     line, hs_first, hs_cnt);
         end
         checks++;
         if (pix_bad != 0) begin
            errors++;
            $display("FAIL line%0d_pixel: got %0d bad pixels, expected 0", line, pix_bad);
         end
         checks++;
         if (ls_def !== 1'b1 || ls_early != 0) begin
            errors++;
            $display("FAIL line%0d_period: got ls=%b at 800 with %0d early pulses, expected ls=1 and 0",
                     line, ls_def, ls_early);
         end
      end
   endtask

   task automatic test_start_sm();
      int flush_bad = 0;
      reset_sm = 1'b0;
      t_sm     = 0;
      for (int i = 0; i < 20 && fs_sm !== 1'b1; i++) begin
         step_sm();
         if (fs_sm !== 1'b1 && {hsync_sm, de_sm, pixel_sm} !== 14'd0) flush_bad++;
      end
      checks++;
      if (fs_sm !== 1'b1 || t_sm != 4 || flush_bad != 0) begin
         errors++;
         $display("FAIL first_frame_start_sm: got fs=%b at cycle %0d flush_bad=%0d, expected fs=1 at cycle 4 and 0",
                  fs_sm, t_sm, flush_bad);
      end
      checks++;
      if ({de_sm, pixel_sm} !== {1'b1, 12'h500}) begin
         errors++;
         $display("FAIL origin_pixel_sm: got de=%b pix=%h, expected de=1 pix=500", de_sm, pixel_sm);
      end
   endtask

   task automatic test_frame_sm();
      int de_err = 0, hs_err = 0, vs_err = 0, mk_err = 0, pix_err = 0, addr_err = 0;
      int vs_cnt = 0, de_late = 0;
      logic [11:0] pix_corner = 12'h000;
      for (int idx = 0; idx < 1152; idx++) begin
         int h, v, sh, sv;
         logic e_de;
         logic [11:0] e_pix;
         logic [7:0] e_addr;
         h     = idx % 48;
         v     = idx / 48;
         e_de  = (h < 32) && (v < 16);
         e_pix = e_de ? {4'h5, 8'((v / 4) * 8 + h / 4)} : 12'h000;
         if (de_sm !== e_de) de_err++;
         if (hsync_sm !== ((h >= 36) && (h < 44))) hs_err++;
         if (vsync_sm !== !((v >= 18) && (v < 20))) vs_err++;
         if (fs_sm !== (idx == 0) || ls_sm !== (h == 0 && v < 16)) mk_err++;
         if (pixel_sm !== e_pix) pix_err++;
         if (vsync_sm === 1'b0) vs_cnt++;
         if (v >= 16 && de_sm !== 1'b0) de_late++;
         if (idx == 15 * 48 + 31) pix_corner = pixel_sm;
         sh     = (idx + 4) % 48;
         sv     = ((idx + 4) % 1152) / 48;
         e_addr = (sh < 32 && sv < 16) ? 8'((sv / 4) * 8 + sh / 4) : 8'h00;
         if (fetch_sm !== e_addr) addr_err++;
         step_sm();
      end
      checks++;
      if (de_err != 0 || de_late != 0) begin
         errors++;
         $display("FAIL frame_de: got %0d wrong de, %0d de in blank lines, expected 0 and 0", de_err, de_late);
      end
      checks++;
      if (hs_err != 0) begin
         errors++;
         $display("FAIL frame_hsync: got %0d wrong cycles, expected 0", hs_err);
      end
      checks++;
      if (vs_err != 0 || vs_cnt != 96) begin
         errors++;
         $display("FAIL frame_vsync: got %0d wrong, %0d asserted cycles, expected 0 and 96", vs_err, vs_cnt);
      end
      checks++;
      if (mk_err != 0) begin
         errors++;
         $display("FAIL frame_markers: got %0d wrong cycles, expected 0", mk_err);
      end
      checks++;
      if (pix_err != 0) begin
         errors++;
         $display("FAIL data_align: got %0d wrong pixels, expected 0", pix_err);
      end
      checks++;
      if (addr_err != 0) begin
         errors++;
         $display("FAIL fetch_addr_sm: got %0d wrong addresses, expected 0", addr_err);
      end
      checks++;
      if (pix_corner !== 12'h51F) begin
         errors++;
         $display("FAIL last_pixel (31,15): got %h expected 51f", pix_corner);
      end
      checks++;
      if (fs_sm !== 1'b1) begin
         errors++;
         $display("FAIL frame_period: got fs=%b after 1152 cycles, expected 1", fs_sm);
      end
   endtask

   task automatic test_mid_reset_sm();
      int hs_cnt = 0, vs_cnt = 0, de_cnt = 0, run = 0, bad_runs = 0, flush_bad = 0;
      repeat (506) step_sm();
      checks++;
      if ({de_sm, pixel_sm} !== {1'b1, 12'h516}) begin
         errors++;
         $display("FAIL pre_reset (26,10): got de=%b pix=%h, expected de=1 pix=516", de_sm, pixel_sm);
      end
      reset_sm = 1'b1;
      step_sm();
      checks++;
      if ({hsync_sm, vsync_sm, de_sm, fs_sm, ls_sm, pixel_sm} !== {5'b01000, 12'h000}) begin
         errors++;
         $display("FAIL mid_reset: got hs/vs/de/fs/ls=%b%b%b%b%b pix=%h, expected 01000 pix=000",
                  hsync_sm, vsync_sm, de_sm, fs_sm, ls_sm, pixel_sm);
      end
      reset_sm = 1'b0;
      t_sm     = 0;
      for (int i = 0; i < 20 && fs_sm !== 1'b1; i++) begin
         step_sm();
         if (fs_sm !== 1'b1 && {hsync_sm, de_sm} !== 2'b00) flush_bad++;
      end
      checks++;
      if (fs_sm !== 1'b1 || t_sm != 4 || flush_bad != 0) begin
         errors++;
         $display("FAIL restart_frame_start: got fs=%b at cycle %0d flush_bad=%0d, expected fs=1 at cycle 4 and 0",
                  fs_sm, t_sm, flush_bad);
      end
      for (int idx = 0; idx < 1152; idx++) begin
         if (hsync_sm === 1'b1) begin
            hs_cnt++;
            run++;
         end else begin
            if (run != 0 && run != 8) bad_runs++;
            run = 0;
         end
         if (vsync_sm === 1'b0) vs_cnt++;
         if (de_sm === 1'b1) de_cnt++;
         step_sm();
      end
      checks++;
      if (hs_cnt != 192 || bad_runs != 0) begin
         errors++;
         $display("FAIL restart_hsync: got %0d asserted cycles, %0d short pulses, expected 192 and 0",
                  hs_cnt, bad_runs);
      end
      checks++;
      if (vs_cnt != 96 || de_cnt != 512) begin
         errors++;
         $display("FAIL restart_frame: got vsync=%0d de=%0d cycles, expected 96 and 512", vs_cnt, de_cnt);
      end
      checks++;
      if (fs_sm !== 1'b1) begin
         errors++;
         $display("FAIL restart_period: got fs=%b after 1152 cycles, expected 1", fs_sm);
      end
   endtask

   initial begin
      reset_def = 1'b1;
      reset_sm  = 1'b1;
      pix_def   = 12'hFFF;
      test_reset();
      test_start_def();
      test_addr_def();
      test_line_def();
      test_start_sm();
      test_frame_sm();
      test_mid_reset_sm();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
